// File: rtl/ram_scan_ctrl_if.sv
// ram_scan_ctrl_if -- bundles the manual write port, the read/scan controls
// and the status outputs of ram_scan_ctrl.
//   master : drives wr_req/wr_addr/wr_data/rd_addr/scan_en/clr_req,
//            observes rd_addr_out/rd_data/wr_done/busy
//   slave  : the RAM controller side (inverse directions)
interface ram_scan_ctrl_if #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 5
);
    logic                  wr_req;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  scan_en;
    logic                  clr_req;
    logic [ADDR_WIDTH-1:0] rd_addr_out;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  wr_done;
    logic                  busy;

    modport master (
        output wr_req, wr_addr, wr_data, rd_addr, scan_en, clr_req,
        input  rd_addr_out, rd_data, wr_done, busy
    );

    modport slave (
        input  wr_req, wr_addr, wr_data, rd_addr, scan_en, clr_req,
        output rd_addr_out, rd_data, wr_done, busy
    );
endinterface

// File: rtl/ram_scan_ctrl.sv
// ram_scan_ctrl -- DATA_WIDTH x 2**ADDR_WIDTH RAM with an edge-triggered
// manual write port, a registered read port that follows either a manual
// address or an auto-scan address stepping every SCAN_TICKS clocks, and a
// sequencer that clears the whole memory one word per cycle.
// Ports:
//   clk_i   : system clock
//   reset_i : asynchronous, active-high reset (memory contents not reset)
//   bus     : ram_scan_ctrl_if.slave
//             wr_req  level; a rising edge requests one write
//             wr_addr/wr_data write address/data
//             rd_addr manual read address (scan_en=0)
//             scan_en 1 = auto-scan read address
//             clr_req pulse; clears the whole memory
//             rd_addr_out/rd_data aligned registered read result
//             wr_done 1-cycle pulse after a write commits
//             busy    high while a clear is running
module ram_scan_ctrl #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 5,
    parameter int SCAN_TICKS = 50000000
) (
    input  logic               clk_i,
    input  logic               reset_i,
    ram_scan_ctrl_if.slave     bus
);
    localparam int DEPTH  = 2 ** ADDR_WIDTH;
    localparam int TICK_W = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam logic [TICK_W-1:0]     TICK_LAST = TICK_W'(SCAN_TICKS - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] clr_ptr_q;
    logic                  busy_q;
    logic                  wr_req_q;
    logic [TICK_W-1:0]     tick_q, tick_d;
    logic [ADDR_WIDTH-1:0] scan_addr_q, scan_addr_d;
    logic [ADDR_WIDTH-1:0] rd_addr_out_q;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  wr_done_q;

    logic                  wr_fire;
    logic                  in_clear;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [ADDR_WIDTH-1:0] sel_addr;

    // wr_req_q resets to 1 so a key held through reset does not fire.
    assign wr_fire  = bus.wr_req & ~wr_req_q;
    assign in_clear = (state_q == ST_CLEAR);

    // The clear sequencer owns the write port; manual writes are dropped.
    always_comb begin
        mem_we    = in_clear | wr_fire;
        mem_waddr = in_clear ? clr_ptr_q : bus.wr_addr;
        mem_wdata = in_clear ? '0 : bus.wr_data;
    end

    assign sel_addr = bus.scan_en ? scan_addr_q : bus.rd_addr;

    // Write-first: a same-cycle write to the read address is forwarded.
    always_comb begin
        rd_data_d = mem_q[sel_addr];
        if (mem_we && (mem_waddr == sel_addr)) begin
            rd_data_d = mem_wdata;
        end
    end

    // Both scan counters freeze while scan_en is low.
    always_comb begin
        tick_d      = tick_q;
        scan_addr_d = scan_addr_q;
        if (bus.scan_en) begin
            if (tick_q == TICK_LAST) begin
                tick_d      = '0;
                scan_addr_d = scan_addr_q + ADDR_WIDTH'(1);
            end else begin
                tick_d = tick_q + TICK_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            clr_ptr_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.clr_req) begin
                        state_q   <= ST_CLEAR;
                        clr_ptr_q <= '0;
                        busy_q    <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    clr_ptr_q <= clr_ptr_q + ADDR_WIDTH'(1);
                    if (clr_ptr_q == ADDR_LAST) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_req_q      <= 1'b1;
            tick_q        <= '0;
            scan_addr_q   <= '0;
            rd_addr_out_q <= '0;
            rd_data_q     <= '0;
            wr_done_q     <= 1'b0;
        end else begin
            wr_req_q      <= bus.wr_req;
            tick_q        <= tick_d;
            scan_addr_q   <= scan_addr_d;
            rd_addr_out_q <= sel_addr;
            rd_data_q     <= rd_data_d;
            wr_done_q     <= wr_fire & ~in_clear;
        end
    end

    assign bus.rd_addr_out = rd_addr_out_q;
    assign bus.rd_data     = rd_data_q;
    assign bus.wr_done     = wr_done_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_ram_scan_ctrl.sv
// Testbench for ram_scan_ctrl: a word-level reference model checks every
// output each cycle, and directed steps pin known literal values.
module tb_ram_scan_ctrl;
    localparam int DW    = 4;
    localparam int AW    = 5;
    localparam int ST    = 4;
    localparam int DEPTH = 32;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ram_scan_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    ram_scan_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SCAN_TICKS(ST)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: memory image, key history, remaining clear words,
    // and the number of clock edges seen with scanning enabled.
    logic [DW-1:0] m_mem   [DEPTH];
    bit            m_known [DEPTH];
    bit            m_prev_req;
    int            m_left, m_idx, m_en;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    bit            e_known, e_done, e_busy;

    initial begin
        for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
        m_prev_req = 1'b1; m_left = 0; m_idx = 0; m_en = 0;
    end

    always @(posedge clk) begin
        bit            fire, idle, we;
        int            wa, sel;
        logic [DW-1:0] wd;
        if (reset) begin
            m_prev_req = 1'b1; m_left = 0; m_idx = 0; m_en = 0;
            e_addr = '0; e_data = '0; e_known = 1'b1; e_done = 1'b0;
        end else begin
            fire = bus.wr_req && !m_prev_req;
            idle = (m_left == 0);
            we = 1'b0; wa = 0; wd = '0;
            if (!idle) begin
                we = 1'b1; wa = m_idx; wd = '0;
            end else if (fire) begin
                we = 1'b1; wa = int'(bus.wr_addr); wd = bus.wr_data;
            end
            sel    = bus.scan_en ? ((m_en / ST) % DEPTH) : int'(bus.rd_addr);
            e_addr = AW'(sel);
            if (we && wa == sel) begin
                e_data = wd; e_known = 1'b1;
            end else begin
                e_data = m_mem[sel]; e_known = m_known[sel];
            end
            e_done = idle && fire;
            if (we) begin
                m_mem[wa] = wd; m_known[wa] = 1'b1;
            end
            m_prev_req = bus.wr_req;
            if (bus.scan_en) m_en++;
            if (!idle) begin
                m_idx++; m_left--;
            end else if (bus.clr_req) begin
                m_left = DEPTH; m_idx = 0;
            end
        end
        e_busy = (m_left != 0);
        #1;
        check("rd_addr_out", bus.rd_addr_out, e_addr);
        if (e_known) check("rd_data", bus.rd_data, e_data);
        check("wr_done", bus.wr_done, e_done);
        check("busy", bus.busy, e_busy);
        if (bus.wr_done === 1'b1) done_cnt++;
    end

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.wr_addr = a; bus.wr_data = d; bus.wr_req = 1'b1;
        @(negedge clk);
        bus.wr_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string nm);
        bus.rd_addr = a;
        @(negedge clk);
        check(nm, bus.rd_data, exp);
        check({nm, "_addr"}, bus.rd_addr_out, a);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (bus.busy === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int n, d0;
        bus.wr_req = 1'b1; bus.wr_addr = '0; bus.wr_data = '0;
        bus.rd_addr = '0;  bus.scan_en = 1'b0; bus.clr_req = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_rd_data", bus.rd_data, 0);
        check("rst_rd_addr_out", bus.rd_addr_out, 0);
        check("rst_wr_done", bus.wr_done, 0);
        check("rst_busy", bus.busy, 0);

        // Key held across reset release must not write.
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("held_through_reset", done_cnt, 0);
        bus.wr_req = 1'b0;
        @(negedge clk);

        do_write(5'h15, 4'hA);
        do_write(5'h0A, 4'h5);
        check("two_writes_done", done_cnt, 2);
        do_read(5'h15, 4'hA, "read_15");
        do_read(5'h0A, 4'h5, "read_0A");

        // Ten-cycle key press gives one write.
        d0 = done_cnt;
        bus.wr_addr = 5'h01; bus.wr_data = 4'h3; bus.wr_req = 1'b1;
        repeat (10) @(negedge clk);
        bus.wr_req = 1'b0;
        @(negedge clk);
        check("long_press_one_done", done_cnt - d0, 1);
        do_read(5'h01, 4'h3, "read_01");

        // Same-cycle read and write of one address.
        bus.rd_addr = 5'h03; bus.wr_addr = 5'h03; bus.wr_data = 4'h7; bus.wr_req = 1'b1;
        @(negedge clk);
        check("bypass_data", bus.rd_data, 4'h7);
        check("bypass_addr", bus.rd_addr_out, 5'h03);
        bus.wr_req = 1'b0;
        @(negedge clk);

        // Scan from reset, four clocks per address.
        reset = 1'b1; bus.scan_en = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("scan_edge4", bus.rd_addr_out, 5'h00);
        @(negedge clk);
        check("scan_edge5", bus.rd_addr_out, 5'h01);
        repeat (123) @(negedge clk);
        check("scan_edge128", bus.rd_addr_out, 5'h1F);
        @(negedge clk);
        check("scan_wrap", bus.rd_addr_out, 5'h00);
        bus.scan_en = 1'b0; bus.rd_addr = 5'h11;
        repeat (10) @(negedge clk);
        check("scan_off_manual", bus.rd_addr_out, 5'h11);
        bus.scan_en = 1'b1;
        repeat (3) @(negedge clk);
        check("scan_resume_hold", bus.rd_addr_out, 5'h00);
        @(negedge clk);
        check("scan_resume_step", bus.rd_addr_out, 5'h01);
        bus.scan_en = 1'b0;
        @(negedge clk);

        // Full clear with a key edge while busy.
        for (int i = 0; i < DEPTH; i++) do_write(AW'(i), 4'hF);
        d0 = done_cnt;
        bus.clr_req = 1'b1;
        @(negedge clk);
        bus.clr_req = 1'b0;
        n = 0;
        while (bus.busy === 1'b1 && n < 100) begin
            if (n == 3) bus.wr_req = 1'b1;
            if (n == 5) bus.wr_req = 1'b0;
            @(negedge clk);
            n++;
        end
        check("clear_busy_cycles", n, 32);
        check("clear_drops_write", done_cnt - d0, 0);
        for (int i = 0; i < DEPTH; i++) do_read(AW'(i), 4'h0, "cleared_word");

        // Write and clear request in the same idle cycle.
        bus.wr_addr = 5'h07; bus.wr_data = 4'h9; bus.wr_req = 1'b1; bus.clr_req = 1'b1;
        @(negedge clk);
        bus.wr_req = 1'b0; bus.clr_req = 1'b0;
        check("wr_clr_done", bus.wr_done, 1);
        check("wr_clr_busy", bus.busy, 1);
        wait_idle(n);
        check("wr_clr_finished", bus.busy, 0);
        do_read(5'h07, 4'h0, "wr_clr_word");

        // Reset partway through a clear.
        for (int i = 0; i < DEPTH; i++) do_write(AW'(i), 4'hF);
        bus.clr_req = 1'b1;
        @(negedge clk);
        bus.clr_req = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midclear_busy_drop", bus.busy, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < DEPTH; i++)
            do_read(AW'(i), (i < 10) ? 4'h0 : 4'hF, "midclear_word");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
